// File: rtl/mac_share_arbiter.sv
// mac_share_arbiter
//   Shares one signed OPW x OPW multiplier between two edge-search requesters.
//   A granted request computes a*x + b*y in two multiplier passes (the b*y
//   pass is skipped when b == 0) and returns the sum with a position code.
// Ports
//   clk, reset          rising-edge clock, async active-high reset
//   nt                  sync flush, aborts any operation, highest priority
//   req0/1, a/b/x/y0/1  requests and operands (operands stable while req high)
//   gnt0/1              one-cycle pulse, operands captured
//   done0/1             one-cycle pulse, res/cls valid for that requester
//   res, cls            sum and position code (00 zero, 10 neg, 01 pos)
//   busy                engine not idle
//   mul_a, mul_b, mul_p shared multiplier interface (product same cycle)
module mac_share_arbiter #(
  parameter int OPW  = 9,
  parameter int ACCW = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              nt,
  input  logic              req0,
  input  logic [OPW-1:0]    a0,
  input  logic [OPW-1:0]    b0,
  input  logic [OPW-1:0]    x0,
  input  logic [OPW-1:0]    y0,
  input  logic              req1,
  input  logic [OPW-1:0]    a1,
  input  logic [OPW-1:0]    b1,
  input  logic [OPW-1:0]    x1,
  input  logic [OPW-1:0]    y1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [ACCW-1:0]   res,
  output logic [1:0]        cls,
  output logic              busy,
  output logic [OPW-1:0]    mul_a,
  output logic [OPW-1:0]    mul_b,
  input  logic [2*OPW-1:0]  mul_p
);

  typedef enum logic [1:0] {IDLE, MUL_AX, MUL_BY, DONE} state_t;

  state_t          state_q, state_d;
  logic [ACCW-1:0] acc_q, acc_d, res_q, res_d;
  logic [OPW-1:0]  a_q, a_d, b_q, b_d, x_q, x_d, y_q, y_d;
  logic            owner_q, owner_d, last_q, last_d;
  logic            win;
  logic [ACCW-1:0] p_ext;

  // Lone requester wins; on a tie the port that was not served last wins.
  assign win   = (req0 && req1) ? ~last_q : req1;
  assign p_ext = {{(ACCW-2*OPW){mul_p[2*OPW-1]}}, mul_p};
  assign busy  = (state_q != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      res_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      y_q     <= y_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    res_d   = res_q;
    a_d     = a_q;
    b_d     = b_q;
    x_d     = x_q;
    y_d     = y_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    done0   = 1'b0;
    done1   = 1'b0;
    mul_a   = '0;
    mul_b   = '0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          a_d     = win ? a1 : a0;
          b_d     = win ? b1 : b0;
          x_d     = win ? x1 : x0;
          y_d     = win ? y1 : y0;
          owner_d = win;
          last_d  = win;
          state_d = MUL_AX;
        end
      end
      MUL_AX: begin
        gnt0    = ~owner_q;
        gnt1    = owner_q;
        mul_a   = a_q;
        mul_b   = x_q;
        acc_d   = p_ext;
        // b == 0 contributes nothing, so the second pass is skipped.
        state_d = (b_q != '0) ? MUL_BY : DONE;
      end
      MUL_BY: begin
        mul_a   = b_q;
        mul_b   = y_q;
        acc_d   = acc_q + p_ext;
        state_d = DONE;
      end
      DONE: begin
        done0   = ~owner_q;
        done1   = owner_q;
        res_d   = acc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything, including pulses of the current cycle.
    if (nt) begin
      state_d = IDLE;
      acc_d   = '0;
      res_d   = '0;
      a_d     = '0;
      b_d     = '0;
      x_d     = '0;
      y_d     = '0;
      owner_d = 1'b0;
      last_d  = 1'b1;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      done0   = 1'b0;
      done1   = 1'b0;
      mul_a   = '0;
      mul_b   = '0;
    end
  end

  // Result is live in DONE and held from res_q otherwise.
  always_comb begin
    res = res_q;
    if (state_q == DONE && !nt) res = acc_q;
    if (res == '0)             cls = 2'b00;
    else if (res[ACCW-1])      cls = 2'b10;
    else                       cls = 2'b01;
  end

endmodule

// File: doc/mac_share_arbiter.md
Name: mac_share_arbiter

Overview:
- Shares the engine's single signed multiplier between the left-edge and right-edge search requesters.
- Each request evaluates the line function a*x + b*y, with operands presented by the requester. The block captures the operands and sequences two multiplier passes (a*x, then b*y) into a 19-bit accumulator.
- Returns the sum together with the 2-bit position code used by the edge search (zero / negative / positive).
- Sits between the per-edge search FSMs and the multiplier. Replaces the hard-wired search_a/search_b/add_out sequencing with an arbitrated, reusable service.

Parameters:
- OPW, 9, operand width (two's complement) for a, b, x, y.
- ACCW, 19, accumulator/result width; must be >= 2*OPW+1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- nt  in  1  synchronous flush (new trapezoid); aborts any operation.
- req0  in  1  left-edge request; held high until gnt0.
- a0, b0, x0, y0  in  OPW each  left-edge operands, stable while req0 is high.
- req1  in  1  right-edge request; held high until gnt1.
- a1, b1, x1, y1  in  OPW each  right-edge operands.
- gnt0, gnt1  out  1  one-cycle pulse: operands captured, requester may change or drop them.
- done0, done1  out  1  one-cycle pulse: res/cls valid for that requester.
- res  out  ACCW  signed a*x + b*y of the completed request.
- cls  out  2  2'b00 res==0, 2'b10 res<0, 2'b01 res>0.
- busy  out  1  high whenever state != IDLE.
- mul_a, mul_b  out  OPW  operands to the shared multiplier (combinational from state and captured operands).
- mul_p  in  2*OPW  signed product of mul_a*mul_b, combinational, same cycle.

Behaviour:
- Reset (async) and nt (sync, has priority over all other activity):
  - state=IDLE; acc=0; captured operands=0; owner=0; last=1 (so port 0 wins first).
  - All outputs 0.
  - An in-flight operation aborted by nt produces no done pulse. Pending requests are re-arbitrated from IDLE on the cycle after nt drops.
- States: IDLE, MUL_AX, MUL_BY, DONE.
- IDLE:
  - If any req, select a winner.
  - Only one req: that port wins.
  - Both reqs: the port != last wins (round-robin).
  - At the clock edge: capture the winner's a, b, x, y; owner<=winner; last<=winner; go to MUL_AX.
- MUL_AX:
  - gnt[owner]=1 for exactly this cycle.
  - mul_a=a, mul_b=x; acc <= sign-extend(mul_p) to ACCW.
  - Next state is MUL_BY if captured b != 0, else DONE (b==0 skip, mirrors horizontal-edge case).
- MUL_BY:
  - mul_a=b, mul_b=y; acc <= acc + sign-extend(mul_p).
  - Next state DONE.
- DONE:
  - done[owner]=1 for one cycle; res=acc; cls derived combinationally from acc (acc[ACCW-1] gives negative).
  - Next state IDLE.
- res and cls hold their last value outside DONE. Only done qualifies them.
- mul_a/mul_b = 0 in IDLE and DONE.
- Latency from capture edge E0:
  - gnt in the cycle after E0.
  - done 3 cycles after E0 (2 cycles when b==0).
  - Throughput: one request per 4 cycles (3 when b==0). No request is accepted in DONE.
- Arithmetic: |a*x|, |b*y| <= 2^16, so the sum fits in 19 bits signed; no saturation, no overflow flag.
  - -256*-256 = 65536 must be correct.
- A req that drops before its grant is not serviced.
- A req still high in the cycle after its gnt is treated as a new request (requesters must drop req on gnt).
- gnt0 & gnt1 and done0 & done1 are never high together.

Test Plan:
- Single left request, a0=3, x0=10, b0=-2, y0=7 -> gnt0 1 cycle after capture; done0 3 cycles after capture; res=16, cls=2'b01; done1 never asserted.
- Both requests in the same cycle, held through the first grant, port1 operands a=-5, x=4, b=1, y=6 -> port0 served first, then port1 immediately after (captured in the next IDLE). Next simultaneous pair after that -> port1 first (alternation). Port1 result res=-14, cls=2'b10.
- b==0 skip, a0=4, x0=-5, b0=0, y0=99 -> no MUL_BY cycle; done0 2 cycles after capture; res=-20.
- Zero and extreme operands:
  - a=5, x=6, b=-3, y=10 -> res=0, cls=2'b00.
  - a=-256, x=-256, b=-256, y=-256 -> res=131072, cls=2'b01.
- nt asserted during MUL_BY -> no done pulse, busy=0 next cycle, last reset to 1. A pending req1 is then granted normally on the cycle after nt drops.
- Async reset pulsed mid MUL_AX, between clock edges -> all outputs 0 immediately; the first post-reset pair of simultaneous requests grants port0.
